st_data_sched: RTL and testbench

In-order scheduler for store-data register lookups. It buffers `StDataLookupUOp`s from dispatch, tracks whether each source tag has been produced, and issues the oldest ready entries to the store-data lookup lanes. Issue honours each lane's ready and squashes entries on branch mispredict or flush. It sits between dispatch and the store-data register-read stage.

---
 rtl/st_data_sched.sv | 173 +++++++++++++++++
 tb/tb_st_data_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/st_data_sched.sv
// ============================================================================
// Module   : st_data_sched
// Purpose  : In-order store-data lookup scheduler with tag wakeup and squash
// Revision : 1.0
// ============================================================================
`default_nettype none

package st_data_sched_pkg;
  localparam int c_TAG_W  = 7;
  localparam int c_SQN_W  = 7;
  localparam int c_OFFS_W = 3;

  typedef logic [c_TAG_W-1:0] Tag;

  typedef struct packed {
    logic                valid;
    Tag                  tag;
    logic [c_SQN_W-1:0]  storeSqN;
    logic [c_OFFS_W-1:0] offs;
  } StDataLookupUOp;

  typedef struct packed {
    logic               taken;
    logic               flush;
    logic [c_SQN_W-1:0] storeSqN;
  } BranchProv;
endpackage

module st_data_sched
  import st_data_sched_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 2,
  parameter int NUM_WB = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  BranchProv      IN_branch,
  input  StDataLookupUOp IN_enq [WIDTH],
  output logic           OUT_enqReady,
  input  logic           IN_wbValid [NUM_WB],
  input  Tag             IN_wbTag [NUM_WB],
  input  logic           IN_ready [WIDTH],
  output StDataLookupUOp OUT_uop [WIDTH]
);

  localparam int c_IDXW = $clog2(DEPTH);
  localparam int c_CNTW = c_IDXW + 1;

  typedef logic [c_IDXW-1:0] idx_t;
  typedef logic [c_CNTW-1:0] cnt_t;

  Tag                  r_tag  [DEPTH];
  logic [c_SQN_W-1:0]  r_sqn  [DEPTH];
  logic [c_OFFS_W-1:0] r_offs [DEPTH];
  logic [DEPTH-1:0]    r_rdy;
  idx_t                r_head;
  idx_t                r_tail;
  cnt_t                r_count;

  logic       w_found;
  cnt_t       w_first;
  idx_t       w_tail_base;
  cnt_t       w_ndeq;
  cnt_t       w_nenq;
  logic       w_deq    [WIDTH];
  logic       w_acc    [WIDTH];
  idx_t       w_wr_idx [WIDTH];
  logic       w_wr_rdy [WIDTH];
  logic [DEPTH-1:0] w_wake;

  // Younger than the branch (signed wrap-aware distance) or any entry on flush.
  function automatic logic f_kill(input BranchProv br, input logic [c_SQN_W-1:0] s);
    logic [c_SQN_W-1:0] d;
    d = s - br.storeSqN;
    return br.taken && (br.flush || ($signed(d) > 0));
  endfunction

  assign OUT_enqReady = (r_count <= cnt_t'(DEPTH - WIDTH));

  // Killed entries form a suffix, so the first killed age becomes the new count.
  always_comb begin
    idx_t v_idx;
    w_found = 1'b0;
    w_first = r_count;
    v_idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      v_idx = r_head + idx_t'(k);
      if (!w_found && (cnt_t'(k) < r_count) && f_kill(IN_branch, r_sqn[v_idx])) begin
        w_found = 1'b1;
        w_first = cnt_t'(k);
      end
    end
    w_tail_base = w_found ? (r_head + idx_t'(w_first)) : r_tail;
  end

  always_comb begin
    idx_t v_idx;
    logic v_prev_p;
    logic v_prev_d;
    logic v_pres;
    v_prev_p = 1'b1;
    v_prev_d = 1'b1;
    v_idx    = '0;
    v_pres   = 1'b0;
    w_ndeq   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      v_idx  = r_head + idx_t'(i);
      v_pres = v_prev_p && (cnt_t'(i) < r_count) && r_rdy[v_idx]
               && !f_kill(IN_branch, r_sqn[v_idx]);
      OUT_uop[i].valid    = v_pres;
      OUT_uop[i].tag      = r_tag[v_idx];
      OUT_uop[i].storeSqN = r_sqn[v_idx];
      OUT_uop[i].offs     = r_offs[v_idx];
      w_deq[i] = v_pres && IN_ready[i] && v_prev_d;
      v_prev_p = v_pres;
      v_prev_d = w_deq[i];
      if (w_deq[i]) w_ndeq = w_ndeq + cnt_t'(1);
    end
  end

  always_comb begin
    cnt_t v_off;
    v_off = '0;
    for (int j = 0; j < WIDTH; j++) begin
      w_acc[j]    = OUT_enqReady && IN_enq[j].valid && !f_kill(IN_branch, IN_enq[j].storeSqN);
      w_wr_idx[j] = w_tail_base + idx_t'(v_off);
      w_wr_rdy[j] = IN_enq[j].tag[c_TAG_W-1];
      for (int w = 0; w < NUM_WB; w++)
        if (IN_wbValid[w] && (IN_wbTag[w] == IN_enq[j].tag)) w_wr_rdy[j] = 1'b1;
      if (w_acc[j]) v_off = v_off + cnt_t'(1);
    end
    w_nenq = v_off;
  end

  always_comb begin
    w_wake = '0;
    for (int e = 0; e < DEPTH; e++)
      for (int w = 0; w < NUM_WB; w++)
        if (IN_wbValid[w] && (IN_wbTag[w] == r_tag[e])) w_wake[e] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_rdy   <= '0;
    end else begin
      r_head  <= r_head + idx_t'(w_ndeq);
      r_tail  <= w_tail_base + idx_t'(w_nenq);
      r_count <= w_first - w_ndeq + w_nenq;
      for (int e = 0; e < DEPTH; e++)
        if (w_wake[e]) r_rdy[e] <= 1'b1;
      for (int j = 0; j < WIDTH; j++)
        if (w_acc[j]) r_rdy[w_wr_idx[j]] <= w_wr_rdy[j];
    end
  end

  // Payload needs no reset: rdy and count gate every use of it.
  always_ff @(posedge clk) begin
    for (int j = 0; j < WIDTH; j++) begin
      if (w_acc[j]) begin
        r_tag[w_wr_idx[j]]  <= IN_enq[j].tag;
        r_sqn[w_wr_idx[j]]  <= IN_enq[j].storeSqN;
        r_offs[w_wr_idx[j]] <= IN_enq[j].offs;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_st_data_sched.sv
// ============================================================================
// Module   : tb_st_data_sched
// Purpose  : Scoreboard bench for st_data_sched
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_st_data_sched;
  import st_data_sched_pkg::*;

  localparam int c_DEPTH  = 8;
  localparam int c_WIDTH  = 2;
  localparam int c_NUM_WB = 4;

  logic           clk;
  logic           rst;
  BranchProv      br;
  StDataLookupUOp enq [c_WIDTH];
  logic           enq_ready;
  logic           wb_valid [c_NUM_WB];
  Tag             wb_tag [c_NUM_WB];
  logic           in_ready [c_WIDTH];
  StDataLookupUOp uop [c_WIDTH];

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  st_data_sched #(.DEPTH(c_DEPTH), .WIDTH(c_WIDTH), .NUM_WB(c_NUM_WB)) dut (
    .clk(clk), .rst(rst), .IN_branch(br), .IN_enq(enq), .OUT_enqReady(enq_ready),
    .IN_wbValid(wb_valid), .IN_wbTag(wb_tag), .IN_ready(in_ready), .OUT_uop(uop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic StDataLookupUOp mk(input int s, input logic [6:0] t);
    StDataLookupUOp u;
    u.valid    = 1'b1;
    u.tag      = t;
    u.storeSqN = 7'(s);
    u.offs     = 3'(s);
    return u;
  endfunction

  task automatic clear_in();
    br = '0;
    for (int j = 0; j < c_WIDTH; j++) enq[j] = '0;
    for (int w = 0; w < c_NUM_WB; w++) begin
      wb_valid[w] = 1'b0;
      wb_tag[w]   = '0;
    end
  endtask

  task automatic set_ready(input logic r1, input logic r0);
    in_ready[1] = r1;
    in_ready[0] = r0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every dequeued uop must be the oldest expected sqN.
  always @(negedge clk) begin
    logic prev;
    prev = 1'b1;
    if (!rst) begin
      for (int i = 0; i < c_WIDTH; i++) begin
        if (uop[i].valid && in_ready[i] && prev) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_issue_sqn", int'(uop[i].storeSqN), -1);
          end else begin
            chk("issue_sqn", int'(uop[i].storeSqN), exp_q.pop_front());
          end
        end else begin
          prev = 1'b0;
        end
      end
    end
  end

  initial begin
    int nxt;
    int cyc;
    rst = 1'b1;
    clear_in();
    set_ready(1'b0, 1'b0);

    // Reset state
    @(negedge clk);
    chk("reset_valid0", int'(uop[0].valid), 0);
    chk("reset_valid1", int'(uop[1].valid), 0);
    chk("reset_enq_ready", int'(enq_ready), 1);
    step();
    rst = 1'b0;

    // Immediate tags issue the next cycle on both lanes
    enq[0] = mk(3, 7'h40);
    enq[1] = mk(4, 7'h41);
    exp_q.push_back(3);
    exp_q.push_back(4);
    step();
    clear_in();
    set_ready(1'b1, 1'b1);
    @(negedge clk);
    chk("imm_valid0", int'(uop[0].valid), 1);
    chk("imm_valid1", int'(uop[1].valid), 1);
    chk("imm_sqn0", int'(uop[0].storeSqN), 3);
    chk("imm_tag0", int'(uop[0].tag), 'h40);
    step();
    @(negedge clk);
    chk("imm_empty", int'(uop[0].valid), 0);

    // Register tag waits for its wakeup
    step();
    enq[0] = mk(5, 7'h12);
    exp_q.push_back(5);
    step();
    clear_in();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("wait_valid0", int'(uop[0].valid), 0);
      step();
    end
    wb_valid[2] = 1'b1;
    wb_tag[2]   = 7'h12;
    @(negedge clk);
    chk("wake_cycle_valid0", int'(uop[0].valid), 0);
    step();
    clear_in();
    @(negedge clk);
    chk("woken_valid0", int'(uop[0].valid), 1);
    chk("woken_sqn0", int'(uop[0].storeSqN), 5);
    step();

    // Lower lane stall blocks the higher lane
    set_ready(1'b0, 1'b0);
    enq[0] = mk(6, 7'h40);
    enq[1] = mk(7, 7'h40);
    exp_q.push_back(6);
    exp_q.push_back(7);
    step();
    clear_in();
    set_ready(1'b1, 1'b0);
    @(negedge clk);
    chk("stall_valid0", int'(uop[0].valid), 1);
    chk("stall_valid1", int'(uop[1].valid), 1);
    step();
    set_ready(1'b1, 1'b1);
    @(negedge clk);
    chk("stall_hold_sqn0", int'(uop[0].storeSqN), 6);
    chk("stall_hold_sqn1", int'(uop[1].storeSqN), 7);
    step();

    // Fill, ignored enqueue while full, then partial squash
    set_ready(1'b0, 1'b0);
    for (int p = 0; p < 4; p++) begin
      enq[0] = mk(10 + 2 * p, 7'h40);
      enq[1] = mk(11 + 2 * p, 7'h40);
      step();
    end
    clear_in();
    enq[0] = mk(18, 7'h40);
    enq[1] = mk(19, 7'h40);
    @(negedge clk);
    chk("full_enq_ready", int'(enq_ready), 0);
    step();
    clear_in();
    exp_q.push_back(10);
    exp_q.push_back(11);
    exp_q.push_back(12);
    br.taken    = 1'b1;
    br.flush    = 1'b0;
    br.storeSqN = 7'd12;
    @(negedge clk);
    chk("branch_head_valid", int'(uop[0].valid), 1);
    step();
    clear_in();
    @(negedge clk);
    chk("post_branch_enq_ready", int'(enq_ready), 1);
    step();
    set_ready(1'b1, 1'b1);
    step();
    step();
    @(negedge clk);
    chk("post_branch_empty", int'(uop[0].valid), 0);
    step();

    // Flush alongside enqueue and a ready head
    set_ready(1'b0, 1'b0);
    enq[0] = mk(22, 7'h40);
    step();
    clear_in();
    br.taken    = 1'b1;
    br.flush    = 1'b1;
    br.storeSqN = 7'd30;
    enq[0] = mk(20, 7'h40);
    enq[1] = mk(21, 7'h40);
    set_ready(1'b1, 1'b1);
    @(negedge clk);
    chk("flush_valid0", int'(uop[0].valid), 0);
    chk("flush_valid1", int'(uop[1].valid), 0);
    step();
    clear_in();
    @(negedge clk);
    chk("flush_empty", int'(uop[0].valid), 0);
    chk("flush_enq_ready", int'(enq_ready), 1);
    step();

    // Wrapping stream with random lane readiness
    nxt = 50;
    cyc = 0;
    while (nxt < 90 && cyc < 400) begin
      clear_in();
      set_ready(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (enq_ready) begin
        enq[0] = mk(nxt, 7'h40);
        enq[1] = mk(nxt + 1, 7'h40);
        exp_q.push_back(nxt);
        exp_q.push_back(nxt + 1);
        nxt += 2;
      end
      step();
      cyc++;
    end
    clear_in();
    set_ready(1'b1, 1'b1);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      step();
      cyc++;
    end
    chk("stream_enqueued", nxt, 90);
    chk("stream_leftover", exp_q.size(), 0);
    @(negedge clk);
    chk("stream_empty", int'(uop[0].valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
